// File: rtl/ouch_tx_packer_if.sv
// ============================================================================
//  Module      : ouch_cmd_if / ouch_st_if
//  Description : Order-command handshake bus and 64-bit Avalon-ST source bus
//                used by the outbound order packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ouch_cmd_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_cmd;
    logic        in_side;
    logic [15:0] in_locate;
    logic [31:0] in_token;
    logic [31:0] in_shares;
    logic [31:0] in_price;

    modport master (
        output in_valid, in_cmd, in_side, in_locate, in_token, in_shares, in_price,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_cmd, in_side, in_locate, in_token, in_shares, in_price,
        output in_ready
    );
endinterface

interface ouch_st_if;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        m_sop;
    logic        m_eop;
    logic [2:0]  m_empty;

    modport master (
        output m_valid, m_data, m_sop, m_eop, m_empty,
        input  m_ready
    );
    modport slave (
        input  m_valid, m_data, m_sop, m_eop, m_empty,
        output m_ready
    );
endinterface

`default_nettype wire

// File: rtl/ouch_tx_packer.sv
// ============================================================================
//  Module      : ouch_tx_packer
//  Description : Serializes enter/cancel order commands into big-endian
//                binary messages on a 64-bit Avalon-ST source.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ouch_tx_packer #(
    parameter logic [31:0] FIRM_ID    = 32'h48465431,
    parameter logic [31:0] TOKEN_INIT = 32'd1
) (
    input  wire logic    clk_100,
    input  wire logic    rst_n,
    ouch_cmd_if.slave    cmd,
    ouch_st_if.master    src,
    output logic         tok_valid,
    output logic [31:0]  tok_id,
    output logic [31:0]  msg_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_B0   = 2'd1;
    localparam logic [1:0] S_B1   = 2'd2;
    localparam logic [1:0] S_B2   = 2'd3;

    localparam logic       CMD_CANCEL = 1'b1;

    logic [1:0]  state_q,     state_d;
    logic        in_ready_q,  in_ready_d;
    logic        cmd_q,       cmd_d;
    logic        side_q,      side_d;
    logic [15:0] locate_q,    locate_d;
    logic [31:0] token_q,     token_d;
    logic [31:0] shares_q,    shares_d;
    logic [31:0] price_q,     price_d;
    logic [31:0] tok_ctr_q,   tok_ctr_d;
    logic        tok_valid_q, tok_valid_d;
    logic [31:0] tok_id_q,    tok_id_d;
    logic [31:0] msg_count_q, msg_count_d;

    logic        m_valid_w;
    logic [63:0] m_data_w;
    logic        m_sop_w;
    logic        m_eop_w;
    logic [2:0]  m_empty_w;
    logic        accept_w;
    logic        fire_w;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            cmd_q       <= 1'b0;
            side_q      <= 1'b0;
            locate_q    <= 16'h0;
            token_q     <= 32'h0;
            shares_q    <= 32'h0;
            price_q     <= 32'h0;
            tok_ctr_q   <= TOKEN_INIT;
            tok_valid_q <= 1'b0;
            tok_id_q    <= 32'h0;
            msg_count_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            cmd_q       <= cmd_d;
            side_q      <= side_d;
            locate_q    <= locate_d;
            token_q     <= token_d;
            shares_q    <= shares_d;
            price_q     <= price_d;
            tok_ctr_q   <= tok_ctr_d;
            tok_valid_q <= tok_valid_d;
            tok_id_q    <= tok_id_d;
            msg_count_q <= msg_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    assign accept_w = cmd.in_valid && in_ready_q;
    assign fire_w   = m_valid_w && src.m_ready;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        side_d      = side_q;
        locate_d    = locate_q;
        token_d     = token_q;
        shares_d    = shares_q;
        price_d     = price_q;
        tok_ctr_d   = tok_ctr_q;
        tok_valid_d = 1'b0;
        tok_id_d    = tok_id_q;
        msg_count_d = msg_count_q;

        case (state_q)
            S_IDLE: begin
                if (accept_w) begin
                    state_d  = S_B0;
                    cmd_d    = cmd.in_cmd;
                    side_d   = cmd.in_side;
                    locate_d = cmd.in_locate;
                    shares_d = cmd.in_shares;
                    price_d  = cmd.in_price;
                    if (cmd.in_cmd == CMD_CANCEL) begin
                        token_d = cmd.in_token;
                    end else begin
                        // Token pulse lands in the same cycle as the first beat.
                        token_d     = tok_ctr_q;
                        tok_ctr_d   = tok_ctr_q + 32'd1;
                        tok_valid_d = 1'b1;
                        tok_id_d    = tok_ctr_q;
                    end
                end
            end
            S_B0: begin
                if (fire_w) state_d = S_B1;
            end
            S_B1: begin
                if (fire_w) state_d = (cmd_q == CMD_CANCEL) ? S_IDLE : S_B2;
            end
            S_B2: begin
                if (fire_w) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (fire_w && m_eop_w) msg_count_d = msg_count_q + 32'd1;

        in_ready_d = (state_d == S_IDLE);
    end

    // ------------------------------------------------------------------
    // Output logic: beats are a pure function of state and latched fields,
    // so they stay bit-stable while the sink stalls.
    // ------------------------------------------------------------------
    always_comb begin
        m_valid_w = 1'b0;
        m_data_w  = 64'h0;
        m_sop_w   = 1'b0;
        m_eop_w   = 1'b0;
        m_empty_w = 3'd0;

        case (state_q)
            S_B0: begin
                m_valid_w = 1'b1;
                m_sop_w   = 1'b1;
                if (cmd_q == CMD_CANCEL)
                    m_data_w = {8'h58, 8'h00, locate_q, token_q};
                else
                    m_data_w = {8'h4F, (side_q ? 8'h53 : 8'h42), locate_q, token_q};
            end
            S_B1: begin
                m_valid_w = 1'b1;
                if (cmd_q == CMD_CANCEL) begin
                    m_data_w  = {shares_q, 32'h0};
                    m_eop_w   = 1'b1;
                    m_empty_w = 3'd4;
                end else begin
                    m_data_w  = {shares_q, price_q};
                end
            end
            S_B2: begin
                m_valid_w = 1'b1;
                m_data_w  = {FIRM_ID, 32'h0};
                m_eop_w   = 1'b1;
                m_empty_w = 3'd4;
            end
            default: ;
        endcase
    end

    assign cmd.in_ready = in_ready_q;
    assign src.m_valid  = m_valid_w;
    assign src.m_data   = m_data_w;
    assign src.m_sop    = m_sop_w;
    assign src.m_eop    = m_eop_w;
    assign src.m_empty  = m_empty_w;
    assign tok_valid    = tok_valid_q;
    assign tok_id       = tok_id_q;
    assign msg_count    = msg_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ouch_tx_packer.sv
// ============================================================================
//  Module      : tb_ouch_tx_packer
//  Description : Directed self-checking bench for the outbound order packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ouch_tx_packer;

    logic clk_100;
    logic rst_n;

    ouch_cmd_if cmd_i ();
    ouch_st_if  st_i ();
    ouch_cmd_if wcmd_i ();
    ouch_st_if  wst_i ();

    logic        tok_valid, wtok_valid;
    logic [31:0] tok_id, wtok_id;
    logic [31:0] msg_count, wmsg_count;

    int n_cmp = 0;
    int n_err = 0;

    ouch_tx_packer u_dut (
        .clk_100   (clk_100),
        .rst_n     (rst_n),
        .cmd       (cmd_i),
        .src       (st_i),
        .tok_valid (tok_valid),
        .tok_id    (tok_id),
        .msg_count (msg_count)
    );

    ouch_tx_packer #(.TOKEN_INIT(32'hFFFF_FFFF)) u_wrap (
        .clk_100   (clk_100),
        .rst_n     (rst_n),
        .cmd       (wcmd_i),
        .src       (wst_i),
        .tok_valid (wtok_valid),
        .tok_id    (wtok_id),
        .msg_count (wmsg_count)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    task automatic check_val(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares {valid,sop,eop,empty,data} of the main source, then steps a cycle.
    task automatic check_beat(input string tag, input logic sop, input logic eop,
                              input logic [2:0] empty, input logic [63:0] data);
        check_val(tag, {st_i.m_valid, st_i.m_sop, st_i.m_eop, st_i.m_empty, st_i.m_data},
                  {1'b1, sop, eop, empty, data});
        @(negedge clk_100);
    endtask

    // Presents one command at a negedge; it is accepted at the following posedge.
    task automatic send_cmd(input logic c, input logic side, input logic [15:0] loc,
                            input logic [31:0] tok, input logic [31:0] sh, input logic [31:0] pr);
        check_val("accept_ready", {69'h0, cmd_i.in_ready}, 70'h1);
        cmd_i.in_valid  = 1'b1;
        cmd_i.in_cmd    = c;
        cmd_i.in_side   = side;
        cmd_i.in_locate = loc;
        cmd_i.in_token  = tok;
        cmd_i.in_shares = sh;
        cmd_i.in_price  = pr;
        @(negedge clk_100);
        cmd_i.in_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd_i.in_valid  = 1'b0;
        wcmd_i.in_valid = 1'b0;
        repeat (3) @(negedge clk_100);
        rst_n = 1'b1;
        @(negedge clk_100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] toks [3];
        int ntok, acc, eops, c_a, c_e;

        rst_n = 1'b0;
        cmd_i.in_valid = 1'b0; cmd_i.in_cmd = 1'b0; cmd_i.in_side = 1'b0;
        cmd_i.in_locate = '0; cmd_i.in_token = '0; cmd_i.in_shares = '0; cmd_i.in_price = '0;
        wcmd_i.in_valid = 1'b0; wcmd_i.in_cmd = 1'b0; wcmd_i.in_side = 1'b0;
        wcmd_i.in_locate = '0; wcmd_i.in_token = '0; wcmd_i.in_shares = '0; wcmd_i.in_price = '0;
        st_i.m_ready  = 1'b1;
        wst_i.m_ready = 1'b1;

        repeat (3) @(negedge clk_100);
        check_val("rst_in_ready", {69'h0, cmd_i.in_ready}, 70'h0);
        check_val("rst_outputs",
                  {st_i.m_valid, st_i.m_sop, st_i.m_eop, st_i.m_empty, st_i.m_data}, 70'h0);
        check_val("rst_tok", {5'h0, tok_valid, tok_id, msg_count}, 70'h0);
        rst_n = 1'b1;
        @(negedge clk_100);

        // Buy enter
        send_cmd(1'b0, 1'b0, 16'h0007, 32'h0, 32'd100, 32'd1500000);
        check_val("t1_tok", {37'h0, tok_valid, tok_id}, {37'h0, 1'b1, 32'd1});
        check_beat("t1_b0", 1'b1, 1'b0, 3'd0, 64'h4F42_0007_0000_0001);
        check_val("t1_tok_pulse", {69'h0, tok_valid}, 70'h0);
        check_beat("t1_b1", 1'b0, 1'b0, 3'd0, 64'h0000_0064_0016_E360);
        check_beat("t1_b2", 1'b0, 1'b1, 3'd4, 64'h4846_5431_0000_0000);
        check_val("t1_idle", {37'h0, st_i.m_valid, msg_count}, {37'h0, 1'b0, 32'd1});

        // Cancel
        send_cmd(1'b1, 1'b0, 16'h0003, 32'd5, 32'd0, 32'hDEAD_BEEF);
        check_val("t2_no_tok", {69'h0, tok_valid}, 70'h0);
        check_beat("t2_b0", 1'b1, 1'b0, 3'd0, 64'h5800_0003_0000_0005);
        check_beat("t2_b1", 1'b0, 1'b1, 3'd4, 64'h0);
        check_val("t2_idle", {37'h0, st_i.m_valid, msg_count}, {37'h0, 1'b0, 32'd2});

        // Backpressure during B1 of a sell enter; a stray command must be ignored
        send_cmd(1'b0, 1'b1, 16'h0001, 32'h0, 32'd10, 32'd20);
        check_val("t3_tok", {37'h0, tok_valid, tok_id}, {37'h0, 1'b1, 32'd2});
        check_beat("t3_b0", 1'b1, 1'b0, 3'd0, 64'h4F53_0001_0000_0002);
        st_i.m_ready = 1'b0;
        cmd_i.in_valid = 1'b1; cmd_i.in_cmd = 1'b1; cmd_i.in_token = 32'd99;
        for (int i = 0; i < 5; i++) begin
            check_val("t3_hold", {st_i.m_valid, st_i.m_sop, st_i.m_eop, st_i.m_empty, st_i.m_data},
                      {1'b1, 1'b0, 1'b0, 3'd0, 64'h0000_000A_0000_0014});
            check_val("t3_busy", {69'h0, cmd_i.in_ready}, 70'h0);
            @(negedge clk_100);
        end
        cmd_i.in_valid = 1'b0;
        st_i.m_ready = 1'b1;
        check_beat("t3_b1", 1'b0, 1'b0, 3'd0, 64'h0000_000A_0000_0014);
        check_beat("t3_b2", 1'b0, 1'b1, 3'd4, 64'h4846_5431_0000_0000);
        check_val("t3_idle", {37'h0, st_i.m_valid, msg_count}, {37'h0, 1'b0, 32'd3});

        // Token wrap on the second instance
        for (int k = 0; k < 2; k++) begin
            wcmd_i.in_valid = 1'b1; wcmd_i.in_cmd = 1'b0; wcmd_i.in_locate = 16'h0002;
            @(negedge clk_100);
            wcmd_i.in_valid = 1'b0;
            check_val(k == 0 ? "t5_tok0" : "t5_tok1", {37'h0, wtok_valid, wtok_id},
                      {37'h0, 1'b1, (k == 0 ? 32'hFFFF_FFFF : 32'h0)});
            check_val(k == 0 ? "t5_b0_0" : "t5_b0_1", {6'h0, wst_i.m_data},
                      {6'h0, 32'h4F42_0002, (k == 0 ? 32'hFFFF_FFFF : 32'h0)});
            repeat (3) @(negedge clk_100);
        end
        check_val("t5_count", {38'h0, wmsg_count}, {38'h0, 32'd2});

        // Reset during B1
        send_cmd(1'b0, 1'b0, 16'h0009, 32'h0, 32'd1, 32'd2);
        @(negedge clk_100);
        check_val("t6_in_b1", {69'h0, st_i.m_valid}, 70'h1);
        rst_n = 1'b0;
        @(negedge clk_100);
        check_val("t6_reset", {36'h0, st_i.m_valid, st_i.m_eop, msg_count},
                  {36'h0, 1'b0, 1'b0, 32'd0});
        rst_n = 1'b1;
        @(negedge clk_100);
        send_cmd(1'b0, 1'b0, 16'h0009, 32'h0, 32'd1, 32'd2);
        check_val("t6_tok", {37'h0, tok_valid, tok_id}, {37'h0, 1'b1, 32'd1});
        repeat (3) @(negedge clk_100);

        // Back-to-back enters with in_valid held high
        do_reset();
        ntok = 0; acc = 0; eops = 0; c_a = 0; c_e = 0;
        cmd_i.in_valid = 1'b1; cmd_i.in_cmd = 1'b0; cmd_i.in_side = 1'b0;
        for (int cyc = 0; cyc < 40 && eops < 3; cyc++) begin
            if (tok_valid && ntok < 3) begin toks[ntok] = tok_id; ntok++; end
            if (cmd_i.in_valid && cmd_i.in_ready) begin
                if (acc == 0) c_a = cyc;
                acc++;
            end
            if (st_i.m_valid && st_i.m_ready && st_i.m_eop) begin
                eops++;
                if (eops == 3) c_e = cyc;
            end
            @(negedge clk_100);
            if (acc == 3) cmd_i.in_valid = 1'b0;
        end
        cmd_i.in_valid = 1'b0;
        check_val("t4_eops", 70'(eops), 70'd3);
        check_val("t4_ntok", 70'(ntok), 70'd3);
        check_val("t4_toks", {6'h0, toks[0][15:0], toks[1][15:0], toks[2][15:0]},
                  {6'h0, 16'd1, 16'd2, 16'd3});
        check_val("t4_cycles", 70'(c_e - c_a + 1), 70'd12);
        check_val("t4_count", {38'h0, msg_count}, {38'h0, 32'd3});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ouch_tx_packer.md
Name: ouch_tx_packer

Overview:
- Outbound order-entry serializer: takes one order command per handshake and emits it as a big-endian binary message on a 64-bit Avalon-ST source toward the HPS DMA.
- It is the transmit counterpart of the inbound ITCH feed path and is driven by strategy logic in the clk_100 domain.
- Assigns order tokens to new orders and counts completed messages.

Parameters:
- FIRM_ID, 32'h48465431, firm identifier placed in enter-order bytes 16-19.
- TOKEN_INIT, 32'd1, first order token assigned after reset.

Ports:
- clk_100  in  1  single clock for the whole block.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid && in_ready.
- in_cmd  in  1  0 = enter order, 1 = cancel.
- in_side  in  1  0 = buy, 1 = sell (enter only).
- in_locate  in  16  stock locate.
- in_token  in  32  token of the order to cancel (cancel only).
- in_shares  in  32  enter: share quantity; cancel: remaining quantity.
- in_price  in  32  price in 1/10000 units (enter only).
- m_valid  out  1  Avalon-ST source valid.
- m_ready  in  1  sink ready.
- m_data  out  64  beat data; byte 0 is m_data[63:56].
- m_sop  out  1  first beat of a message.
- m_eop  out  1  last beat of a message.
- m_empty  out  3  unused bytes on the eop beat; 0 on all other beats.
- tok_valid  out  1  one-cycle pulse: token assigned to an accepted enter.
- tok_id  out  32  the assigned token.
- msg_count  out  32  messages completed (eop handshakes), wraps modulo 2^32.

Behaviour:
- Reset values: in_ready=0 during reset and 1 in the first cycle after; m_valid, m_sop, m_eop, tok_valid=0; m_data, m_empty, tok_id, msg_count=0; token counter=TOKEN_INIT; FSM=IDLE.
- FSM states: IDLE, B0, B1, B2.
- in_ready=1 only in IDLE.
- Accept: all command fields are registered and the FSM goes IDLE->B0. m_valid rises the next cycle (1-cycle latency).
- Enter message (20 bytes, 3 beats):
  - B0 = {8'h4F, side char (8'h42 'B' / 8'h53 'S'), locate, token}, m_sop=1.
  - B1 = {shares, price}.
  - B2 = {FIRM_ID, 32'h0}, m_eop=1, m_empty=4.
- Cancel message (12 bytes, 2 beats):
  - B0 = {8'h58, 8'h00, locate, in_token}, m_sop=1.
  - B1 = {shares, 32'h0}, m_eop=1, m_empty=4.
  - B2 is never entered for a cancel.
- Beat advance: a beat advances only on m_valid && m_ready. While m_valid && !m_ready, m_data, m_sop, m_eop and m_empty are held stable.
- m_valid never deasserts mid-message except on reset.
- The eop handshake returns the FSM to IDLE and increments msg_count. This costs one bubble cycle, so peak throughput is one message per 4 cycles (enter) or 3 cycles (cancel) with m_ready=1.
- Token assignment (enter only): on acceptance the current counter value is latched as the message token. The counter then increments, wrapping 0xFFFFFFFF->0x00000000.
- tok_valid pulses in the cycle m_valid first rises, with tok_id = the latched token. Cancels do not pulse tok_valid and do not move the counter.
- Reset mid-message: all outputs return to reset values at the next edge and the partial message is abandoned with no eop. msg_count resets to 0 and the token counter to TOKEN_INIT.
- m_ready asserted while m_valid=0 has no effect.
- in_valid while not IDLE is ignored; the command is held off by in_ready=0.

Test Plan:
1. Buy enter: locate=16'h0007, shares=100, price=1500000, m_ready=1 -> 3 beats: 64'h4F42_0007_0000_0001, 64'h0000_0064_0016_E360, 64'h4846_5431_0000_0000 with eop and empty=4. tok_valid pulses with tok_id=1; msg_count=1.
2. Cancel: in_token=5, locate=3, shares=0 -> 2 beats: 64'h5800_0003_0000_0005, then 64'h0 with eop and empty=4. No tok_valid pulse; token counter unchanged.
3. Backpressure: m_ready=0 for 5 cycles during B1 of an enter -> beat held bit-stable; no beat lost or repeated; in_ready stays 0 throughout.
4. Back-to-back: 3 enters with in_valid held high and m_ready=1 -> tokens 1, 2, 3; exactly 12 cycles from the first accept to the third eop; msg_count=3.
5. Token wrap: TOKEN_INIT=32'hFFFFFFFF, two enters -> tok_id = FFFFFFFF then 00000000.
6. rst_n low during B1 -> next edge: m_valid=0, msg_count=0. First enter after release carries token TOKEN_INIT.
